// File: rtl/d3_proc_pkg.sv
// rtl/d3_proc_pkg.sv - shared types and constants for the D3 processing datapath
package d3_proc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int PROD_W       = 32;
    localparam int MULT_N_DEF   = 25;
    localparam int PIPE_LAT_DEF = 2;

    // Smallest accumulator that cannot wrap when every tap returns the maximum product.
    function automatic int acc_width(input int taps);
        return PROD_W + $clog2(taps);
    endfunction

    localparam int ACC_W_DEF = acc_width(MULT_N_DEF);

endpackage

// File: rtl/conv_tap_acc.sv
// rtl/conv_tap_acc.sv - single-channel unsigned product accumulator with clear/enable
module conv_tap_acc
    import d3_proc_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic              clkf,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc
);

    always_ff @(posedge clkf or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - tap sequencer and two-channel accumulator for the coefficient multiply pass
module conv_seq_ctrl
    import d3_proc_pkg::*;
#(
    parameter int MULT_N   = MULT_N_DEF,
    parameter int NLOG     = $clog2(MULT_N),
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic              clkf,
    input  logic              rst,
    input  logic              coef_loaded,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              SAMP_WE,
    output logic [NLOG-1:0]   SAMP_WADDR,
    output logic [NLOG-1:0]   SAMP_RADDR,
    output logic [NLOG-1:0]   ADDRB_RAMK,
    input  logic [PROD_W-1:0] PROD_A,
    input  logic [PROD_W-1:0] PROD_B,
    output logic [ACC_W-1:0]  ACC_OUT_A,
    output logic [ACC_W-1:0]  ACC_OUT_B,
    output logic              out_valid,
    output logic              busy,
    output logic              drop_err
);

    localparam int              DCW      = $clog2(PIPE_LAT) + 1;
    localparam logic [NLOG-1:0] LAST_IDX = NLOG'(MULT_N - 1);

    seq_state_t          state;
    logic [NLOG-1:0]     wr_ptr;
    logic [PIPE_LAT-1:0] tap_sr;
    logic [DCW-1:0]      drain_cnt;
    logic [ACC_W-1:0]    acc_a;
    logic [ACC_W-1:0]    acc_b;
    logic                accept;
    logic                tap_vld;

    assign sample_ready = (state == ST_IDLE) && coef_loaded;
    assign accept       = sample_valid && sample_ready;
    assign SAMP_WE      = accept;
    assign SAMP_WADDR   = wr_ptr;
    assign busy         = (state != ST_IDLE);
    assign tap_vld      = tap_sr[PIPE_LAT-1];

    // SAMP_RADDR tracks (base - k) mod MULT_N by decrementing alongside k.
    always_ff @(posedge clkf or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            ADDRB_RAMK <= '0;
            SAMP_RADDR <= '0;
            tap_sr     <= '0;
            drain_cnt  <= '0;
            ACC_OUT_A  <= '0;
            ACC_OUT_B  <= '0;
            out_valid  <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            tap_sr    <= tap_sr << 1;
            if (sample_valid && !sample_ready) begin
                drop_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_ptr     <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + NLOG'(1);
                        ADDRB_RAMK <= '0;
                        SAMP_RADDR <= wr_ptr;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    tap_sr <= (tap_sr << 1) | PIPE_LAT'(1);
                    if (ADDRB_RAMK == LAST_IDX) begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        ADDRB_RAMK <= ADDRB_RAMK + NLOG'(1);
                        SAMP_RADDR <= (SAMP_RADDR == '0) ? LAST_IDX : SAMP_RADDR - NLOG'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DCW'(PIPE_LAT - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                ST_DONE: begin
                    ACC_OUT_A <= acc_a;
                    ACC_OUT_B <= acc_b;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    conv_tap_acc #(.ACC_W(ACC_W)) u_acc_a (
        .clkf (clkf),
        .rst  (rst),
        .clr  (accept),
        .en   (tap_vld),
        .prod (PROD_A),
        .acc  (acc_a)
    );

    conv_tap_acc #(.ACC_W(ACC_W)) u_acc_b (
        .clkf (clkf),
        .rst  (rst),
        .clr  (accept),
        .en   (tap_vld),
        .prod (PROD_B),
        .acc  (acc_b)
    );

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - directed self-checking bench for conv_seq_ctrl
module tb_conv_seq_ctrl;

    localparam int MULT_N = 25;
    localparam int NLOG   = 5;
    localparam int ACC_W  = 37;

    logic             clkf = 1'b0;
    logic             rst = 1'b1;
    logic             coef_loaded = 1'b0;
    logic             sample_valid = 1'b0;
    logic             sample_ready;
    logic             SAMP_WE;
    logic [NLOG-1:0]  SAMP_WADDR;
    logic [NLOG-1:0]  SAMP_RADDR;
    logic [NLOG-1:0]  ADDRB_RAMK;
    logic [31:0]      PROD_A;
    logic [31:0]      PROD_B;
    logic [ACC_W-1:0] ACC_OUT_A;
    logic [ACC_W-1:0] ACC_OUT_B;
    logic             out_valid;
    logic             busy;
    logic             drop_err;

    int          n_chk = 0;
    int          n_err = 0;
    int          exp_wp = 0;
    int          ak_log [64];
    int          ar_log [64];
    logic [31:0] sa = '0;
    logic [31:0] sb = '0;
    logic        force_max = 1'b0;
    logic [31:0] coef_mem [MULT_N];
    logic [31:0] buf_a [MULT_N];
    logic [31:0] buf_b [MULT_N];
    logic [31:0] rd_k, rd_a, rd_b;

    conv_seq_ctrl dut (
        .clkf         (clkf),
        .rst          (rst),
        .coef_loaded  (coef_loaded),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .SAMP_WE      (SAMP_WE),
        .SAMP_WADDR   (SAMP_WADDR),
        .SAMP_RADDR   (SAMP_RADDR),
        .ADDRB_RAMK   (ADDRB_RAMK),
        .PROD_A       (PROD_A),
        .PROD_B       (PROD_B),
        .ACC_OUT_A    (ACC_OUT_A),
        .ACC_OUT_B    (ACC_OUT_B),
        .out_valid    (out_valid),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    always #5 clkf = ~clkf;

    // Sample buffer, coefficient RAM read register, then multiplier register: two cycles.
    always @(posedge clkf) begin
        if (rst) begin
            for (int i = 0; i < MULT_N; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
            rd_k   <= '0;
            rd_a   <= '0;
            rd_b   <= '0;
            PROD_A <= '0;
            PROD_B <= '0;
        end else begin
            if (SAMP_WE) begin
                buf_a[SAMP_WADDR] <= sa;
                buf_b[SAMP_WADDR] <= sb;
            end
            rd_k   <= coef_mem[ADDRB_RAMK];
            rd_a   <= buf_a[SAMP_RADDR];
            rd_b   <= buf_b[SAMP_RADDR];
            PROD_A <= force_max ? 32'hFFFF_FFFF : rd_k * rd_a;
            PROD_B <= rd_k * rd_b;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int drop_at,
                        output int lat, output logic [ACC_W-1:0] ra, output logic [ACC_W-1:0] rb);
        int t;
        @(negedge clkf);
        sa = a;
        sb = b;
        sample_valid = 1'b1;
        #1;
        chk("samp_we", SAMP_WE, 1);
        chk("samp_waddr", SAMP_WADDR, exp_wp);
        @(posedge clkf);
        #1;
        sample_valid = 1'b0;
        exp_wp = (exp_wp == MULT_N - 1) ? 0 : exp_wp + 1;
        chk("busy_run", busy, 1);
        ak_log[0] = int'(ADDRB_RAMK);
        ar_log[0] = int'(SAMP_RADDR);
        t = 0;
        while (!out_valid && t < 60) begin
            @(posedge clkf);
            #1;
            t++;
            ak_log[t] = int'(ADDRB_RAMK);
            ar_log[t] = int'(SAMP_RADDR);
            if (t == drop_at) coef_loaded = 1'b0;
        end
        if (!out_valid) chk("pass_timeout", 0, 1);
        lat = t;
        ra  = ACC_OUT_A;
        rb  = ACC_OUT_B;
    endtask

    initial begin
        int               lat;
        int               errs;
        int               kk;
        int               seen;
        int               acc_c [$];
        logic             we_log [100];
        logic             dl_log [100];
        logic [ACC_W-1:0] ra, rb;

        for (int i = 0; i < MULT_N; i++) coef_mem[i] = 32'd1;

        repeat (3) @(posedge clkf);
        #1;
        chk("rst_ready", sample_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_acc_a", ACC_OUT_A, 0);
        chk("rst_acc_b", ACC_OUT_B, 0);
        chk("rst_addrb", ADDRB_RAMK, 0);
        chk("rst_raddr", SAMP_RADDR, 0);
        chk("rst_waddr", SAMP_WADDR, 0);
        chk("rst_we", SAMP_WE, 0);

        @(negedge clkf);
        rst = 1'b0;
        coef_loaded = 1'b1;

        for (int i = 1; i <= 25; i++) begin
            send(32'(i), 32'(100 + i), 0, lat, ra, rb);
            if (i == 1) begin
                chk("p1_latency", lat, 28);
                chk("p1_acc_a", ra, 1);
                chk("p1_acc_b", rb, 101);
            end
            if (i == 4) begin
                chk("p4_acc_a", ra, 10);
                errs = 0;
                for (int t = 0; t <= 26; t++) begin
                    kk = (t < 25) ? t : 24;
                    if (ak_log[t] != kk) errs++;
                    if (ar_log[t] != (3 - kk + 25) % 25) errs++;
                end
                chk("addr_seq_errs", errs, 0);
                chk("raddr_k0", ar_log[0], 3);
                chk("raddr_k3", ar_log[3], 0);
                chk("raddr_k4_wrap", ar_log[4], 24);
                chk("raddr_k24", ar_log[24], 4);
                chk("addrb_k24", ak_log[24], 24);
                chk("raddr_drain_hold", ar_log[26], 4);
                chk("addrb_drain_hold", ak_log[26], 24);
            end
            if (i == 25) begin
                chk("p25_acc_a", ra, 325);
                chk("p25_acc_b", rb, 2825);
            end
        end

        send(32'd26, 32'd0, 0, lat, ra, rb);
        chk("p26_latency", lat, 28);
        chk("p26_acc_a", ra, 350);
        chk("p26_acc_b", rb, 2724);
        @(posedge clkf);
        #1;
        chk("out_valid_one_cycle", out_valid, 0);
        chk("acc_out_hold", ACC_OUT_A, 350);
        chk("drop_err_clean", drop_err, 0);

        force_max = 1'b1;
        send(32'd0, 32'd0, 0, lat, ra, rb);
        force_max = 1'b0;
        chk("max_latency", lat, 28);
        chk("max_acc_a", ra, 37'h18_FFFF_FFE7);

        @(negedge clkf);
        sa = 32'd7;
        sb = 32'd0;
        sample_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            we_log[c] = SAMP_WE;
            @(posedge clkf);
            #1;
            dl_log[c] = drop_err;
            @(negedge clkf);
        end
        sample_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (we_log[c]) begin
                acc_c.push_back(c);
                exp_wp = (exp_wp == MULT_N - 1) ? 0 : exp_wp + 1;
            end
        end
        chk("cont_accepts", acc_c.size(), 4);
        chk("cont_first", acc_c[0], 0);
        chk("cont_gap1", acc_c[1] - acc_c[0], 29);
        chk("cont_gap3", acc_c[3] - acc_c[2], 29);
        chk("cont_drop_before", dl_log[0], 0);
        chk("cont_drop_first_rej", dl_log[1], 1);
        chk("cont_drop_sticky", dl_log[99], 1);
        seen = 0;
        while (busy && seen < 60) begin
            @(posedge clkf);
            #1;
            seen++;
        end
        chk("cont_idle", busy, 0);

        @(negedge clkf);
        coef_loaded = 1'b0;
        sample_valid = 1'b1;
        #1;
        chk("nocoef_ready", sample_ready, 0);
        chk("nocoef_we", SAMP_WE, 0);
        @(posedge clkf);
        #1;
        sample_valid = 1'b0;
        chk("nocoef_busy", busy, 0);
        chk("nocoef_drop_err", drop_err, 1);

        @(negedge clkf);
        coef_loaded = 1'b1;
        send(32'd0, 32'd0, 5, lat, ra, rb);
        chk("coefdrop_latency", lat, 28);
        chk("coefdrop_out_valid", out_valid, 1);
        chk("coefdrop_ready", sample_ready, 0);

        @(negedge clkf);
        coef_loaded = 1'b1;
        sample_valid = 1'b1;
        @(posedge clkf);
        #1;
        sample_valid = 1'b0;
        repeat (10) @(posedge clkf);
        #1;
        chk("pre_rst_tap", ADDRB_RAMK, 10);
        chk("pre_rst_drop", drop_err, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_addrb", ADDRB_RAMK, 0);
        chk("arst_raddr", SAMP_RADDR, 0);
        chk("arst_waddr", SAMP_WADDR, 0);
        chk("arst_busy", busy, 0);
        chk("arst_acc_a", ACC_OUT_A, 0);
        chk("arst_drop", drop_err, 0);
        chk("arst_out_valid", out_valid, 0);
        @(negedge clkf);
        @(negedge clkf);
        rst = 1'b0;
        exp_wp = 0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clkf);
            #1;
            if (out_valid) seen++;
        end
        chk("arst_no_out_valid", seen, 0);

        send(32'd5, 32'd6, 0, lat, ra, rb);
        chk("post_rst_latency", lat, 28);
        chk("post_rst_acc_a", ra, 5);
        chk("post_rst_acc_b", rb, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
